// File: rtl/jk_pkg.sv
// Shared definitions for the JK bank arbiter: JK command encodings and the
// round-robin winner search.
package jk_pkg;

    localparam int unsigned MAX_NREQ = 8;
    localparam int unsigned MAX_IDW  = 3;

    // {j,k} command encodings
    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_CLR  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TOG  = 2'b11;

    typedef struct packed {
        logic               valid;
        logic [MAX_IDW-1:0] idx;
    } rr_pick_t;

    // First eligible requester at or after ptr, wrapping modulo nreq.
    // ptr is always < nreq, so one conditional subtraction implements the wrap.
    function automatic rr_pick_t rr_pick(input logic [MAX_NREQ-1:0] eligible,
                                         input logic [MAX_IDW-1:0]  ptr,
                                         input int unsigned         nreq);
        rr_pick_t    res;
        int unsigned cand;
        res = '0;
        for (int unsigned off = 0; off < MAX_NREQ; off++) begin
            cand = 32'(ptr) + off;
            if (cand >= nreq) cand = cand - nreq;
            if (off < nreq && !res.valid && eligible[cand[MAX_IDW-1:0]]) begin
                res.valid = 1'b1;
                res.idx   = cand[MAX_IDW-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with enable.
// Ports: clk, rst_n (async active-low), en (apply j/k this edge), j, k, q.
module jk_cell
    import jk_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic j,
    input  logic k,
    output logic q
);

    // JK update: hold / clear / set / toggle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else if (en) begin
            case ({j, k})
                JK_CLR:  q <= 1'b0;
                JK_SET:  q <= 1'b1;
                JK_TOG:  q <= ~q;
                default: q <= q;
            endcase
        end
    end

endmodule

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter granting at most one JK command per clock into a shared
// bank of WIDTH JK cells.
// Ports: clk, rst_n (async active-low), clr_all (sync bulk clear, top priority),
//        req/req_idx/req_jk (per-requester command, packed per requester),
//        ack (registered one-hot apply pulse), gnt_id (last granted requester),
//        q (bank state), q_bar (~q).
module jk_bank_arbiter
    import jk_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IDXW  = $clog2(WIDTH),
    parameter int unsigned IDW   = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr_all,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*IDXW-1:0]   req_idx,
    input  logic [NREQ*2-1:0]      req_jk,
    output logic [NREQ-1:0]        ack,
    output logic [IDW-1:0]         gnt_id,
    output logic [WIDTH-1:0]       q,
    output logic [WIDTH-1:0]       q_bar
);

    // Elaboration-time parameter checks
    if ((WIDTH & (WIDTH - 1)) != 0 || WIDTH < 2 || WIDTH > 64) begin : g_bad_width
        $error("jk_bank_arbiter: WIDTH must be a power of 2 in 2..64");
    end
    if (NREQ < 2 || NREQ > MAX_NREQ) begin : g_bad_nreq
        $error("jk_bank_arbiter: NREQ must be in 2..8");
    end

    logic [IDW-1:0]  rr_ptr;
    logic [NREQ-1:0] eligible_c;
    rr_pick_t        pick_c;
    logic [IDXW-1:0] win_idx_c;
    logic [1:0]      win_jk_c;

    // Arbitration: a requester acked this cycle is masked so a held req is not
    // granted twice for the same command.
    always_comb begin
        eligible_c = req & ~ack;
        pick_c     = rr_pick(MAX_NREQ'(eligible_c), MAX_IDW'(rr_ptr), NREQ);
        win_idx_c  = req_idx[pick_c.idx*IDXW +: IDXW];
        win_jk_c   = req_jk[pick_c.idx*2 +: 2];
    end

    // Grant bookkeeping; clr_all consumes no command and freezes the pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack    <= '0;
            gnt_id <= '0;
            rr_ptr <= '0;
        end else if (clr_all) begin
            ack    <= '0;
        end else if (pick_c.valid) begin
            ack    <= NREQ'(1) << pick_c.idx;
            gnt_id <= IDW'(pick_c.idx);
            rr_ptr <= (pick_c.idx == MAX_IDW'(NREQ - 1)) ? '0 : IDW'(pick_c.idx + 1'b1);
        end else begin
            ack    <= '0;
        end
    end

    // Cell bank: clr_all forces a clear command into every cell
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        logic en_c;
        assign en_c = clr_all | (pick_c.valid & (win_idx_c == IDXW'(i)));

        jk_cell u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (en_c),
            .j     (~clr_all & win_jk_c[1]),
            .k     (clr_all | win_jk_c[0]),
            .q     (q[i])
        );
    end

    assign q_bar = ~q;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
module tb_jk_bank_arbiter;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned IDXW  = 3;
    localparam int unsigned IDW   = 2;

    localparam logic [1:0] C_HOLD = 2'b00;
    localparam logic [1:0] C_SET  = 2'b10;
    localparam logic [1:0] C_TOG  = 2'b11;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 clr_all;
    logic [NREQ-1:0]      req;
    logic [NREQ*IDXW-1:0] req_idx;
    logic [NREQ*2-1:0]    req_jk;
    logic [NREQ-1:0]      ack;
    logic [IDW-1:0]       gnt_id;
    logic [WIDTH-1:0]     q;
    logic [WIDTH-1:0]     q_bar;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    jk_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_all (clr_all),
        .req     (req),
        .req_idx (req_idx),
        .req_jk  (req_jk),
        .ack     (ack),
        .gnt_id  (gnt_id),
        .q       (q),
        .q_bar   (q_bar)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input int r, input logic [IDXW-1:0] idx, input logic [1:0] jk);
        req_idx[r*IDXW +: IDXW] = idx;
        req_jk[r*2 +: 2]        = jk;
        req[r]                  = 1'b1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        clr_all = 1'b0;
        req     = '0;
        req_idx = '0;
        req_jk  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Post one command, wait (bounded) for its ack, drop req in the ack cycle
    task automatic issue(input int r, input logic [IDXW-1:0] idx, input logic [1:0] jk);
        bit got;
        got = 1'b0;
        set_cmd(r, idx, jk);
        for (int n = 0; n < 8; n++) begin
            step();
            if (ack[r]) begin
                got = 1'b1;
                break;
            end
        end
        chk_cnt++;
        if (got !== 1'b1) $display("FAIL issue_ack_timeout: req %0d got ack %b want ack within 8 cycles", r, ack);
        else pass_cnt++;
        req[r] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        clr_all = 1'b0;
        req     = '0;
        req_idx = '0;
        req_jk  = '0;
        #12;
        chk_cnt++;
        if (q !== 8'h00) $display("FAIL reset_q: got %h want %h", q, 8'h00); else pass_cnt++;
        chk_cnt++;
        if (q_bar !== 8'hFF) $display("FAIL reset_q_bar: got %h want %h", q_bar, 8'hFF); else pass_cnt++;
        chk_cnt++;
        if (ack !== 4'b0000) $display("FAIL reset_ack: got %b want %b", ack, 4'b0000); else pass_cnt++;
        chk_cnt++;
        if (gnt_id !== 2'd0) $display("FAIL reset_gnt_id: got %0d want %0d", gnt_id, 0); else pass_cnt++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        set_cmd(2, 3'd5, C_SET);
        step();
        chk_cnt++;
        if (q !== 8'h20) $display("FAIL single_q: got %h want %h", q, 8'h20); else pass_cnt++;
        chk_cnt++;
        if (ack !== 4'b0100) $display("FAIL single_ack: got %b want %b", ack, 4'b0100); else pass_cnt++;
        chk_cnt++;
        if (gnt_id !== 2'd2) $display("FAIL single_gnt_id: got %0d want %0d", gnt_id, 2); else pass_cnt++;
        req[2] = 1'b0;
        step();
        chk_cnt++;
        if (ack !== 4'b0000) $display("FAIL single_ack_drop: got %b want %b", ack, 4'b0000); else pass_cnt++;
        chk_cnt++;
        if (q !== 8'h20 || q_bar !== 8'hDF) $display("FAIL single_hold_q: got %h/%h want %h/%h", q, q_bar, 8'h20, 8'hDF); else pass_cnt++;
        chk_cnt++;
        if (gnt_id !== 2'd2) $display("FAIL single_gnt_hold: got %0d want %0d", gnt_id, 2); else pass_cnt++;
    endtask

    // All four hold toggle commands on idx=i; expect strict 0,1,2,3 rotation
    task automatic test_round_robin();
        logic [WIDTH-1:0] qm;
        logic [NREQ-1:0]  exp_ack;
        do_reset();
        qm = 8'h00;
        for (int r = 0; r < 4; r++) set_cmd(r, 3'(r), C_TOG);
        for (int c = 0; c < 8; c++) begin
            step();
            qm[c % 4] = ~qm[c % 4];
            exp_ack   = 4'b0001 << (c % 4);
            chk_cnt++;
            if (ack !== exp_ack) $display("FAIL rr_ack[%0d]: got %b want %b", c, ack, exp_ack); else pass_cnt++;
            chk_cnt++;
            if (gnt_id !== 2'(c % 4)) $display("FAIL rr_gnt[%0d]: got %0d want %0d", c, gnt_id, c % 4); else pass_cnt++;
            chk_cnt++;
            if (q !== qm) $display("FAIL rr_q[%0d]: got %h want %h", c, q, qm); else pass_cnt++;
        end
        req = '0;
        step();
        chk_cnt++;
        if (ack !== 4'b0000) $display("FAIL rr_idle_ack: got %b want %b", ack, 4'b0000); else pass_cnt++;
    endtask

    task automatic test_same_index();
        do_reset();
        set_cmd(0, 3'd3, C_TOG);
        set_cmd(1, 3'd3, C_TOG);
        step();
        chk_cnt++;
        if (ack !== 4'b0001) $display("FAIL same_ack0: got %b want %b", ack, 4'b0001); else pass_cnt++;
        chk_cnt++;
        if (q !== 8'h08) $display("FAIL same_q_first: got %h want %h", q, 8'h08); else pass_cnt++;
        req[0] = 1'b0;
        step();
        chk_cnt++;
        if (ack !== 4'b0010) $display("FAIL same_ack1: got %b want %b", ack, 4'b0010); else pass_cnt++;
        chk_cnt++;
        if (q !== 8'h00) $display("FAIL same_q_second: got %h want %h", q, 8'h00); else pass_cnt++;
        req[1] = 1'b0;
        step();
        chk_cnt++;
        if (ack !== 4'b0000) $display("FAIL same_ack_idle: got %b want %b", ack, 4'b0000); else pass_cnt++;
    endtask

    task automatic test_clr_all();
        do_reset();
        for (int b = 0; b < 8; b++) issue(0, 3'(b), C_SET);
        chk_cnt++;
        if (q !== 8'hFF) $display("FAIL clr_setup_q: got %h want %h", q, 8'hFF); else pass_cnt++;
        set_cmd(1, 3'd2, C_SET);
        clr_all = 1'b1;
        step();
        chk_cnt++;
        if (q !== 8'h00) $display("FAIL clr_q: got %h want %h", q, 8'h00); else pass_cnt++;
        chk_cnt++;
        if (ack !== 4'b0000) $display("FAIL clr_ack: got %b want %b", ack, 4'b0000); else pass_cnt++;
        chk_cnt++;
        if (gnt_id !== 2'd0) $display("FAIL clr_gnt_hold: got %0d want %0d", gnt_id, 0); else pass_cnt++;
        clr_all = 1'b0;
        step();
        chk_cnt++;
        if (ack !== 4'b0010) $display("FAIL clr_pending_ack: got %b want %b", ack, 4'b0010); else pass_cnt++;
        chk_cnt++;
        if (gnt_id !== 2'd1) $display("FAIL clr_pending_gnt: got %0d want %0d", gnt_id, 1); else pass_cnt++;
        chk_cnt++;
        if (q !== 8'h04) $display("FAIL clr_pending_q: got %h want %h", q, 8'h04); else pass_cnt++;
        req[1] = 1'b0;
        step();
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int r = 0; r < 4; r++) set_cmd(r, 3'(r), C_TOG);
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk_cnt++;
        if (q !== 8'h00) $display("FAIL async_q: got %h want %h", q, 8'h00); else pass_cnt++;
        chk_cnt++;
        if (ack !== 4'b0000) $display("FAIL async_ack: got %b want %b", ack, 4'b0000); else pass_cnt++;
        chk_cnt++;
        if (gnt_id !== 2'd0) $display("FAIL async_gnt: got %0d want %0d", gnt_id, 0); else pass_cnt++;
        req = 4'b1000;
        #1;
        rst_n = 1'b1;
        step();
        chk_cnt++;
        if (ack !== 4'b1000) $display("FAIL async_first_ack: got %b want %b", ack, 4'b1000); else pass_cnt++;
        chk_cnt++;
        if (gnt_id !== 2'd3) $display("FAIL async_first_gnt: got %0d want %0d", gnt_id, 3); else pass_cnt++;
        chk_cnt++;
        if (q !== 8'h08) $display("FAIL async_first_q: got %h want %h", q, 8'h08); else pass_cnt++;
        req = '0;
        step();
    endtask

    task automatic test_hold();
        do_reset();
        issue(0, 3'd7, C_SET);
        step();
        chk_cnt++;
        if (q !== 8'h80) $display("FAIL hold_setup_q: got %h want %h", q, 8'h80); else pass_cnt++;
        set_cmd(0, 3'd7, C_HOLD);
        step();
        chk_cnt++;
        if (ack !== 4'b0001) $display("FAIL hold_ack: got %b want %b", ack, 4'b0001); else pass_cnt++;
        chk_cnt++;
        if (q !== 8'h80) $display("FAIL hold_q: got %h want %h", q, 8'h80); else pass_cnt++;
        chk_cnt++;
        if (q_bar !== 8'h7F) $display("FAIL hold_q_bar: got %h want %h", q_bar, 8'h7F); else pass_cnt++;
        req[0] = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_same_index();
        test_clr_all();
        test_async_reset();
        test_hold();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/jk_bank_arbiter.md
Name: jk_bank_arbiter

Overview:
- Round-robin arbiter that shares one bank of WIDTH JK flip-flop cells between NREQ requesters.
- Each requester posts one JK command (hold/clear/set/toggle) aimed at one bit index.
- At most one command is granted and applied per clock.
- Sits between control FSMs and the shared flag/status register bank built from JK cells.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, number of JK cells in the bank (power of 2, 2..64).
- IDXW, $clog2(WIDTH), bit-index width.
- IDW, $clog2(NREQ), grant-id width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- clr_all  in  1  synchronous bulk clear of the bank; highest priority.
- req  in  NREQ  per-requester command request; level-held until acked.
- req_idx  in  NREQ*IDXW  target bit of requester i, packed at slice [i*IDXW +: IDXW].
- req_jk  in  NREQ*2  {j,k} of requester i, packed at slice [i*2 +: 2].
- ack  out  NREQ  one-hot, registered; one-cycle pulse for the requester whose command was applied.
- gnt_id  out  IDW  index of the last granted requester, registered.
- q  out  WIDTH  bank state.
- q_bar  out  WIDTH  bitwise ~q.

Behaviour:
- Reset (async, immediate on rst_n low): q=0, ack=0, gnt_id=0, rr_ptr=0. Arbitration resumes at the first rising edge after release.
- JK semantics per cell:
  - 00 hold.
  - 01 clear.
  - 10 set.
  - 11 toggle (q <= ~q). Never X.
- Eligibility: eligible[i] = req[i] & ~ack[i]. A requester acked this cycle is masked, so a held req cannot be granted twice.
- Requester protocol: drop req, or present a new command, in the cycle ack[i]=1. This gives a maximum rate of one command per requester every 2 cycles.
- Arbitration: combinational search starting at rr_ptr, ascending with wrap modulo NREQ; the first eligible requester wins.
- At the rising edge when a winner w exists and clr_all=0:
  - q[req_idx[w]] is updated per req_jk[w]; all other bits hold.
  - ack <= onehot(w); gnt_id <= w; rr_ptr <= (w+1) mod NREQ.
- When no requester is eligible: ack <= 0; gnt_id and rr_ptr hold.
- clr_all=1 at an edge:
  - q <= 0; ack <= 0; rr_ptr and gnt_id hold.
  - No command is consumed; pending requesters keep req high and are served afterward.
- Latency: a command is visible on q and ack at the first edge after it becomes eligible and wins. Worst-case wait for a continuously requesting master is NREQ grants.
- Cycle after a command with jk=00: ack still pulses; q is unchanged.
- Two requesters targeting the same index: serialized in round-robin order; each op applies to the result of the previous one. Two toggles return the bit to its original value.
- req_idx out of range: not possible for power-of-2 WIDTH. WIDTH must be a power of 2; the implementation enforces this with an elaboration-time check.
- No combinational path from req to ack, q, or gnt_id.

Decomposition:
- Package jk_pkg holds:
  - JK_HOLD=2'b00, JK_CLR=2'b01, JK_SET=2'b10, JK_TOG=2'b11.
  - Function rr_pick(eligible, ptr) returning the winner index and a valid flag.
- Sub-module jk_cell: one JK flop with async active-low reset, enable, and j/k inputs, implementing toggle on 11. The bank is a generate loop of WIDTH jk_cell instances. A cell's enable is asserted only when (winner valid & idx match) or clr_all; clr_all forces jk=01.

Test Plan:
- Reset then single request: req[2]=1, idx=5, jk=10 → after 1 edge q=8'h20, ack=4'b0100, gnt_id=2, rr_ptr=3. Requester drops req → next cycle ack=0.
- All four requesting continuously, each with jk=11 on idx=i → grant order 0,1,2,3,0..., each requester acked every 4th grant window, never in consecutive cycles. q bits 0..3 toggle in that order.
- Same-index conflict: q=0; req0 and req1 both jk=11 on idx=3 → q[3]=1 after the first grant, back to 0 after the second. Acks on successive grants: ack0, then ack1.
- clr_all while req1 is pending, q=8'hFF → q=0, ack=0, req1 still pending. The next edge applies req1 with ack1=1.
- Async reset mid-burst: rst_n low between edges → q, ack, gnt_id clear immediately without a clock edge. After release with req3 high, the first grant goes to 3 (search from ptr 0).
- Hold command: req0 jk=00 idx=7 with q=8'h80 → q stays 8'h80, ack=4'b0001. The q_bar==~q check passes throughout.
